// File: rtl/coax_rx_buffer.sv
// Receive word buffer behind coax_rx: stages each word to tag the frame's last word,
// turns receiver errors into in-band markers and queues everything for host readout.
module coax_rx_buffer #(
   parameter int unsigned DEPTH = 256
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] rx_data,
   input  logic       rx_strobe,
   input  logic       rx_active,
   input  logic       rx_error,
   input  logic       clear,
   input  logic       read_strobe,
   output logic [9:0] data,
   output logic       data_last,
   output logic       data_error,
   output logic       empty,
   output logic       full,
   output logic       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [11:0] ERR_ENTRY = {1'b1, 1'b1, 10'h000};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECEIVE,
      ST_DISCARD
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [9:0]    r_stg_word, w_stg_word_nxt;
   logic          r_stg_valid, w_stg_valid_nxt;
   logic          r_err_pend, w_err_pend_nxt;
   logic          w_wr_en;
   logic [11:0]   w_wr_entry;

   logic [11:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [11:0]   r_head;
   logic          r_empty;
   logic          r_overflow;
   logic          w_full, w_rd_acc, w_wr_acc, w_wr_drop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_DISCARD;
         r_stg_word  <= '0;
         r_stg_valid <= 1'b0;
         r_err_pend  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_stg_word  <= w_stg_word_nxt;
         r_stg_valid <= w_stg_valid_nxt;
         r_err_pend  <= w_err_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_stg_word_nxt  = r_stg_word;
      w_stg_valid_nxt = r_stg_valid;
      w_err_pend_nxt  = r_err_pend;
      w_wr_en         = 1'b0;
      w_wr_entry      = '0;
      case (r_state)
         ST_IDLE: begin
            if (rx_error) begin
               w_wr_en     = 1'b1;
               w_wr_entry  = ERR_ENTRY;
               w_state_nxt = ST_DISCARD;
            end else if (rx_strobe) begin
               w_stg_word_nxt  = rx_data;
               w_stg_valid_nxt = 1'b1;
               w_state_nxt     = ST_RECEIVE;
            end
         end
         ST_RECEIVE: begin
            // Staged word is flushed first; the error marker follows via the pending flag.
            if (rx_error) begin
               w_wr_en         = r_stg_valid;
               w_wr_entry      = {2'b00, r_stg_word};
               w_stg_valid_nxt = 1'b0;
               w_err_pend_nxt  = 1'b1;
               w_state_nxt     = ST_DISCARD;
            end else if (rx_strobe) begin
               w_wr_en         = r_stg_valid;
               w_wr_entry      = {2'b00, r_stg_word};
               w_stg_word_nxt  = rx_data;
               w_stg_valid_nxt = 1'b1;
            end else if (!rx_active) begin
               w_wr_en         = r_stg_valid;
               w_wr_entry      = {2'b01, r_stg_word};
               w_stg_valid_nxt = 1'b0;
               w_state_nxt     = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (r_err_pend) begin
               w_wr_en        = 1'b1;
               w_wr_entry     = ERR_ENTRY;
               w_err_pend_nxt = 1'b0;
            end
            if (!rx_active && !rx_error) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_DISCARD;
      endcase
      if (clear) begin
         w_state_nxt     = ST_DISCARD;
         w_stg_valid_nxt = 1'b0;
         w_err_pend_nxt  = 1'b0;
         w_wr_en         = 1'b0;
      end
   end

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_rd_acc  = read_strobe && !r_empty;
   assign w_wr_acc  = w_wr_en && (!w_full || w_rd_acc);
   assign w_wr_drop = w_wr_en && !w_wr_acc;

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= w_wr_entry;
   end

   // Occupancy includes the entry held in the output register until it is popped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_head     <= '0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_head     <= '0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_wr_drop) r_overflow <= 1'b1;
         if (w_rd_acc) begin
            r_empty <= 1'b1;
         end else if (r_empty && (r_count != '0)) begin
            r_empty <= 1'b0;
            r_head  <= r_mem[r_rd_ptr];
         end
      end
   end

   assign data       = r_head[9:0];
   assign data_last  = r_head[10];
   assign data_error = r_head[11];
   assign empty      = r_empty;
   assign full       = w_full;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Scoreboard bench for coax_rx_buffer (DEPTH = 4): stimulus pushes expected entries,
// a monitor pops the DUT and compares.
module tb_coax_rx_buffer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] rx_data;
   logic       rx_strobe, rx_active, rx_error, clear, read_strobe;
   logic [9:0] data;
   logic       data_last, data_error, empty, full, overflow;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [11:0] sb[$];
   logic       drain_en = 1'b1;
   int         pop_reqs = 0;
   int         pops_done = 0;

   always #5 clk = ~clk;

   coax_rx_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_strobe(rx_strobe),
      .rx_active(rx_active), .rx_error(rx_error), .clear(clear),
      .read_strobe(read_strobe), .data(data), .data_last(data_last),
      .data_error(data_error), .empty(empty), .full(full), .overflow(overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: pops a presented entry and compares it against the scoreboard head.
   initial begin
      logic [11:0] got;
      read_strobe = 1'b0;
      forever begin
         @(negedge clk);
         read_strobe = 1'b0;
         if (reset_n && !empty && (drain_en || pops_done < pop_reqs)) begin
            if (pops_done < pop_reqs) pops_done++;
            got = {data_error, data_last, data};
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_entry: got %03h with scoreboard empty", got);
            end else begin
               check("entry", got, sb.pop_front());
            end
            read_strobe = 1'b1;
         end
      end
   end

   task automatic strobe(input logic [9:0] w);
      rx_data = w;
      rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      tick();
   endtask

   task automatic single_frame(input logic [9:0] w);
      rx_active = 1'b1;
      tick();
      rx_data = w;
      rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      tick();
   endtask

   task automatic drain_wait(input string name);
      int k;
      drain_en = 1'b1;
      k = 0;
      while ((sb.size() != 0 || !empty) && k < 300) begin
         tick();
         k++;
      end
      repeat (3) tick();
      check({name, "_sb_empty"}, sb.size(), 0);
      check({name, "_empty"}, empty, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      rx_data = '0; rx_strobe = 0; rx_active = 0; rx_error = 0; clear = 0;
      repeat (3) tick();
      check("rst_data", data, 0);
      check("rst_last", data_last, 0);
      check("rst_error", data_error, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      reset_n = 1'b1;
      repeat (2) tick();

      // Basic three-word frame
      sb.push_back({2'b00, 10'h0A1});
      sb.push_back({2'b00, 10'h155});
      sb.push_back({2'b01, 10'h3FF});
      rx_active = 1'b1;
      tick();
      strobe(10'h0A1);
      strobe(10'h155);
      strobe(10'h3FF);
      rx_active = 1'b0;
      repeat (2) tick();
      drain_wait("frame3");

      // Error mid-frame, trailing strobes discarded, then a clean frame
      sb.push_back({2'b00, 10'h011});
      sb.push_back({2'b00, 10'h022});
      sb.push_back({2'b11, 10'h000});
      sb.push_back({2'b01, 10'h055});
      rx_active = 1'b1;
      tick();
      strobe(10'h011);
      strobe(10'h022);
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      strobe(10'h033);
      strobe(10'h044);
      rx_active = 1'b0;
      repeat (2) tick();
      single_frame(10'h055);
      tick();
      drain_wait("errframe");

      // Overflow with DEPTH = 4
      drain_en = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         if (i <= 4) sb.push_back({2'b01, 10'(10'h300 + i)});
         single_frame(10'(10'h300 + i));
         check($sformatf("ovf_full_%0d", i), full, (i >= 4) ? 1 : 0);
         check($sformatf("ovf_overflow_%0d", i), overflow, (i >= 5) ? 1 : 0);
      end
      drain_wait("ovf");
      check("ovf_sticky", overflow, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_overflow", overflow, 0);
      check("clear_empty", empty, 1);
      tick();

      // Full FIFO: pop and write in the same cycle
      drain_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         sb.push_back({2'b01, 10'(10'h3A0 + i)});
         single_frame(10'(10'h3A0 + i));
      end
      tick();
      check("fullrw_full_before", full, 1);
      sb.push_back({2'b01, 10'h3A5});
      rx_active = 1'b1;
      tick();
      rx_data = 10'h3A5;
      rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      #1 pop_reqs++;
      tick();
      rx_active = 1'b0;
      tick();
      check("fullrw_full_after", full, 1);
      check("fullrw_overflow", overflow, 0);
      check("fullrw_popped", pops_done, 1);
      drain_wait("fullrw");

      // Strobe coinciding with rx_active falling
      sb.push_back({2'b00, 10'h100});
      sb.push_back({2'b01, 10'h200});
      rx_active = 1'b1;
      tick();
      strobe(10'h100);
      rx_data = 10'h200;
      rx_strobe = 1'b1;
      rx_active = 1'b0;
      tick();
      rx_strobe = 1'b0;
      repeat (2) tick();
      drain_wait("strobe_fall");

      // Reset mid-frame; released while rx_active is still high
      rx_active = 1'b1;
      tick();
      strobe(10'h0F1);
      reset_n = 1'b0;
      #1;
      check("midrst_empty", empty, 1);
      check("midrst_full", full, 0);
      check("midrst_overflow", overflow, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      strobe(10'h0F2);
      strobe(10'h0F3);
      rx_active = 1'b0;
      repeat (3) tick();
      check("midrst_nothing_captured", empty, 1);
      sb.push_back({2'b01, 10'h0F4});
      single_frame(10'h0F4);
      drain_wait("postrst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/coax_rx_buffer.md
# coax_rx_buffer

Receive-side word buffer that sits directly downstream of `coax_rx`. It captures each 10-bit word the receiver produces and tags the last word of every frame. It converts receiver errors into in-band error entries and holds everything in a FIFO. The host interface drains that FIFO over the shared data bus at its own pace.

## Interface

Parameters:
- `DEPTH`, 256: FIFO entries; power of 2, ≥ 4. Address width is log2(DEPTH); the occupancy counter is one bit wider.

Ports:
- `clk`  in  1  system clock (38 MHz domain, same as `coax_rx`)
- `reset_n`  in  1  asynchronous, active-low reset
- `rx_data`  in  10  received word; valid only when `rx_strobe` = 1
- `rx_strobe`  in  1  one-cycle pulse, new word on `rx_data`
- `rx_active`  in  1  high while the receiver is inside a frame
- `rx_error`  in  1  receiver error level
- `clear`  in  1  synchronous flush of FIFO, staging register and `overflow`
- `read_strobe`  in  1  pop head entry; ignored while `empty` = 1
- `data`  out  10  head entry word
- `data_last`  out  1  head entry is the final word of its frame
- `data_error`  out  1  head entry is an error marker
- `empty`  out  1  no valid head entry on outputs
- `full`  out  1  occupancy = DEPTH
- `overflow`  out  1  sticky: at least one entry was dropped

## Operation

- Entry format: {error, last, word[9:0]}, 12 bits.
- Staging register: holds one word with a valid bit, so that `last` can be attached once the frame end is known.
- State machine with states IDLE, RECEIVE, DISCARD:
  - IDLE: `rx_strobe` loads staging (valid = 1) and moves to RECEIVE. `rx_error` = 1 writes an error entry {1,1,10'h000} and moves to DISCARD.
  - RECEIVE:
    - `rx_strobe` with staging valid writes staging as {0,0,word} and loads the new word.
    - `rx_active` = 0 with no strobe writes staging as {0,1,word}, clears valid and goes to IDLE.
    - `rx_error` = 1 writes staging (if valid) as {0,0,word}. The error entry {1,1,10'h000} is written on the next cycle. The state goes to DISCARD.
  - DISCARD: `rx_strobe` is ignored. Return to IDLE when `rx_active` = 0 and `rx_error` = 0.
- Priority when events coincide in RECEIVE: error > strobe > frame end.
- Strobe and `rx_active` falling in the same cycle: the staged word is written with last = 0. The new word is loaded, and the frame end is applied on the next cycle.
- At most one FIFO write per cycle. The error entry's deferred write uses a pending flag.
- Full handling: a write while `full` = 1 and no accepted read in the same cycle drops the entry and sets `overflow`. A write and a read in the same cycle while full both succeed.
- `clear`: empties the FIFO, invalidates staging, clears `overflow` and the pending error, and sets the state to DISCARD. Any frame in progress is discarded.
- Reset: `reset_n` = 0 mid-frame aborts everything. After release the state is DISCARD, so a partial frame is never captured.

## Timing

- Reset values: `data` = 0, `data_last` = 0, `data_error` = 0, `empty` = 1, `full` = 0, `overflow` = 0. State is DISCARD, staging is invalid, occupancy is 0.
- Outputs are registered. An entry written at edge T into an empty FIFO is presented after edge T+1 (`empty` falls).
- A pop sampled at edge T holds `empty` high after edge T. The next entry, if any, is presented after edge T+1. Maximum drain rate is one entry per 2 cycles.
- `full` and `overflow` update at the same edge as the write or read that changes occupancy.
- Word latency:
  - Non-final word: written at the edge sampling the following `rx_strobe`.
  - Final word: written at the first edge sampling `rx_active` = 0.
- Pointers wrap modulo DEPTH. Occupancy is tracked by a log2(DEPTH)+1-bit counter.

## Test plan

- Frame of 3 strobes (0x0A1, 0x155, 0x3FF), then `rx_active` falls. Three pops, 2 cycles apart, return 0x0A1 / 0x155 / 0x3FF. `data_last` = 0,0,1 and `data_error` = 0 throughout; `empty` = 1 afterward.
- Frame of 2 words (0x011, 0x022), then `rx_error` pulses mid-frame, then 2 more strobes. FIFO holds {0,0,0x011}, {0,0,0x022}, {1,1,0x000} only. The next clean frame after `rx_active` = 0 is captured normally.
- DEPTH = 4: write 6 single-word frames without reading. `full` = 1 after the 4th and `overflow` = 1 after the 5th. Pops return the first 4 words in order.
- Full FIFO with a pop coinciding with a write: no drop, `overflow` stays 0, occupancy stays 4.
- Strobe on the same cycle `rx_active` falls (words 0x100, 0x200). Entries are {0,0,0x100}, {0,1,0x200}.
- `reset_n` asserted mid-frame, then released while `rx_active` = 1 and 2 more strobes arrive. No entries are captured until `rx_active` goes low. The next frame is captured.
